// File: rtl/fifo_ram_dp.sv
// Dual-port storage for the synchronous FIFO: one synchronous write port and
// one asynchronous read port. Kept separate so a registered-read BRAM variant
// can be dropped in later without touching the FIFO control logic.
module fifo_ram_dp #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] r_addr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   // Storage is deliberately not reset; validity is tracked by the FIFO count.
   logic [DATA_W-1:0] mem [DEPTH];

   // Write port: store the word on the rising edge when enabled.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[w_addr] <= wdata;
      end
   end

   // Read port is combinational so the head word is visible without latency.
   assign rdata = mem[r_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with show-ahead read, occupancy count,
// programmable almost-full/almost-empty thresholds, synchronous flush and
// one-cycle overflow/underflow error pulses.
module fifo_sync_param #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 4,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CNT_W = ADDR_W + 1;

   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

`ifndef SYNTHESIS
   // Out-of-range thresholds would make the flags meaningless.
   initial begin
      if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin
         $error("fifo_sync_param: AF_LEVEL=%0d outside 1..%0d", AF_LEVEL, DEPTH);
      end
      if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin
         $error("fifo_sync_param: AE_LEVEL=%0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
      end
      if (ADDR_W < 1 || DATA_W < 1) begin
         $error("fifo_sync_param: DATA_W=%0d ADDR_W=%0d must be >= 1", DATA_W, ADDR_W);
      end
   end
`endif

   logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
   logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;

   logic              push_ok;
   logic              pop_ok;
   logic              wr_en;

   // Flags decode from the registered count only, so no input reaches them.
   assign full         = (count_q == DEPTH_CNT);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_CNT);
   assign almost_empty = (count_q <= AE_CNT);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // Acceptance uses the pre-edge flags; a flush suppresses both requests.
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign wr_en   = push_ok & ~clear;

   // Next-state for pointers, occupancy and error pulses.
   always_comb begin
      w_ptr_d     = w_ptr_q;
      r_ptr_d     = r_ptr_q;
      count_d     = count_q;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;

      if (clear) begin
         w_ptr_d = '0;
         r_ptr_d = '0;
         count_d = '0;
      end else begin
         overflow_d  = push & full;
         underflow_d = pop & empty;
         if (push_ok) begin
            w_ptr_d = w_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            r_ptr_d = r_ptr_q + 1'b1;
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Registered state with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w_ptr_q     <= '0;
         r_ptr_q     <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         w_ptr_q     <= w_ptr_d;
         r_ptr_q     <= r_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifo_ram_dp #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk    (clk),
      .wr_en  (wr_en),
      .w_addr (w_ptr_q),
      .wdata  (push_data),
      .r_addr (r_ptr_q),
      .rdata  (pop_data)
   );

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param (DEPTH = 4, AF = 3, AE = 1),
// compared against a queue-based reference model.
module tb_fifo_sync_param;

   localparam int DW    = 8;
   localparam int AW    = 2;
   localparam int DEPTH = 4;
   localparam int AF    = 3;
   localparam int AE    = 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clear;
   logic          push;
   logic [DW-1:0] push_data;
   logic          pop;
   logic [DW-1:0] pop_data;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] q [$];
   logic          exp_ovf = 1'b0;
   logic          exp_unf = 1'b0;

   always #5 clk = ~clk;

   fifo_sync_param #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .AF_LEVEL (AF),
      .AE_LEVEL (AE)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .push         (push),
      .push_data    (push_data),
      .pop          (pop),
      .pop_data     (pop_data),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   // Drive one clock of stimulus and advance the reference model.
   task automatic step(input logic r, input logic c, input logic ps,
                       input logic [DW-1:0] pd, input logic pp);
      bit pre_full, pre_empty;
      rst_n = r; clear = c; push = ps; push_data = pd; pop = pp;
      pre_full  = (q.size() == DEPTH);
      pre_empty = (q.size() == 0);
      @(posedge clk);
      #1;
      if (!r || c) begin
         q.delete();
         exp_ovf = 1'b0;
         exp_unf = 1'b0;
      end else begin
         exp_ovf = ps && pre_full;
         exp_unf = pp && pre_empty;
         if (pp && !pre_empty) void'(q.pop_front());
         if (ps && !pre_full)  q.push_back(pd);
      end
      rst_n = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0;
   endtask

   task automatic test_reset();
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      checks++;
      if (count !== 3'd0 || empty !== 1'b1 || almost_empty !== 1'b1 ||
          full !== 1'b0 || almost_full !== 1'b0 || overflow !== 1'b0 ||
          underflow !== 1'b0) begin
         failures++;
         $display("FAIL reset: count=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b want 0 1 1 0 0 0 0",
                  count, empty, almost_empty, full, almost_full, overflow, underflow);
      end
   endtask

   task automatic test_fill();
      logic [DW-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 1'b1, vals[i], 1'b0);
         checks++;
         if (count !== 3'(i + 1) || pop_data !== 8'h11 ||
             almost_empty !== (i + 1 <= AE) || almost_full !== (i + 1 >= AF) ||
             full !== (i + 1 == DEPTH) || empty !== 1'b0) begin
            failures++;
            $display("FAIL fill%0d: count=%0d data=%h ae=%b af=%b f=%b e=%b want count=%0d data=11",
                     i, count, pop_data, almost_empty, almost_full, full, empty, i + 1);
         end
      end
   endtask

   task automatic test_overflow_drain();
      logic [DW-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      step(1'b1, 1'b0, 1'b1, 8'h55, 1'b0);
      checks++;
      if (overflow !== 1'b1 || count !== 3'd4) begin
         failures++;
         $display("FAIL overflow: ov=%b count=%0d want ov=1 count=4", overflow, count);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (pop_data !== vals[i]) begin
            failures++;
            $display("FAIL drain%0d: data=%h want %h", i, pop_data, vals[i]);
         end
         step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
         if (i == 0) begin
            checks++;
            if (overflow !== 1'b0) begin
               failures++;
               $display("FAIL overflow_pulse_len: ov=%b want 0", overflow);
            end
         end
      end
      checks++;
      if (empty !== 1'b1 || count !== 3'd0) begin
         failures++;
         $display("FAIL drained: empty=%b count=%0d want 1 0", empty, count);
      end
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      checks++;
      if (underflow !== 1'b1 || count !== 3'd0) begin
         failures++;
         $display("FAIL underflow: un=%b count=%0d want 1 0", underflow, count);
      end
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      checks++;
      if (underflow !== 1'b0) begin
         failures++;
         $display("FAIL underflow_pulse_len: un=%b want 0", underflow);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
         checks++;
         if (pop_data !== 8'(8'hC0 + i) || count !== 3'd1) begin
            failures++;
            $display("FAIL wrap%0d: data=%h count=%0d want %h 1", i, pop_data, count, 8'(8'hC0 + i));
         end
         step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      end
      step(1'b1, 1'b0, 1'b1, 8'hB1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 8'hB2, 1'b0);
      step(1'b1, 1'b0, 1'b1, 8'hA0, 1'b1);
      checks++;
      if (count !== 3'd2 || pop_data !== 8'hB2) begin
         failures++;
         $display("FAIL wrap_simul: count=%0d data=%h want 2 b2", count, pop_data);
      end
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      checks++;
      if (pop_data !== 8'hA0 || count !== 3'd1) begin
         failures++;
         $display("FAIL wrap_tail: data=%h count=%0d want a0 1", pop_data, count);
      end
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
   endtask

   task automatic test_simul();
      step(1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
      checks++;
      if (count !== 3'd1 || pop_data !== 8'h77 || underflow !== 1'b1 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL simul_empty: count=%0d data=%h un=%b ov=%b want 1 77 1 0",
                  count, pop_data, underflow, overflow);
      end
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
      step(1'b1, 1'b0, 1'b1, 8'hEE, 1'b1);
      checks++;
      if (count !== 3'd3 || overflow !== 1'b1 || underflow !== 1'b0 || pop_data !== 8'h80) begin
         failures++;
         $display("FAIL simul_full: count=%0d ov=%b un=%b data=%h want 3 1 0 80",
                  count, overflow, underflow, pop_data);
      end
   endtask

   task automatic test_clear_reset();
      step(1'b1, 1'b1, 1'b1, 8'h99, 1'b0);
      checks++;
      if (count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 ||
          almost_empty !== 1'b1 || almost_full !== 1'b0 || full !== 1'b0) begin
         failures++;
         $display("FAIL clear: count=%0d e=%b ov=%b un=%b ae=%b af=%b f=%b want 0 1 0 0 1 0 0",
                  count, empty, overflow, underflow, almost_empty, almost_full, full);
      end
      step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
      checks++;
      if (underflow !== 1'b0 || count !== 3'd0) begin
         failures++;
         $display("FAIL clear_pop: un=%b count=%0d want 0 0", underflow, count);
      end
      step(1'b1, 1'b0, 1'b1, 8'h12, 1'b0);
      step(1'b1, 1'b0, 1'b1, 8'h34, 1'b0);
      step(1'b0, 1'b0, 1'b1, 8'h56, 1'b1);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      checks++;
      if (count !== 3'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0 ||
          almost_full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
         failures++;
         $display("FAIL midreset: count=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b want 0 1 1 0 0 0 0",
                  count, empty, almost_empty, full, almost_full, overflow, underflow);
      end
   endtask

   task automatic test_random();
      int n;
      int bad = 0;
      for (int i = 0; i < 400; i++) begin
         logic r, c, ps, pp;
         r  = ($urandom_range(0, 99) != 0);
         c  = ($urandom_range(0, 39) == 0);
         ps = ($urandom_range(0, 99) < 55);
         pp = ($urandom_range(0, 99) < 50);
         step(r, c, ps, 8'($urandom), pp);
         n = q.size();
         checks++;
         if (count !== 3'(n) || empty !== (n == 0) || full !== (n == DEPTH) ||
             almost_full !== (n >= AF) || almost_empty !== (n <= AE) ||
             overflow !== exp_ovf || underflow !== exp_unf ||
             (n > 0 && pop_data !== q[0])) begin
            failures++;
            bad++;
            if (bad <= 10)
               $display("FAIL random%0d: count=%0d e=%b f=%b af=%b ae=%b ov=%b un=%b data=%h want count=%0d ov=%b un=%b data=%h",
                        i, count, empty, full, almost_full, almost_empty, overflow, underflow,
                        pop_data, n, exp_ovf, exp_unf, (n > 0) ? q[0] : 8'h00);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
      test_reset();
      test_fill();
      test_overflow_drain();
      test_wrap();
      test_simul();
      test_clear_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
